sram_data_port: RTL and testbench

//  MEM-stage data-memory port of the pipelined CPU: turns memRead/memWrite + address/data

---
 rtl/sram_data_port_pkg.sv | 28 ++
 rtl/sram_data_port.sv | 96 +++++++++
 tb/tb_sram_data_port.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_data_port_pkg.sv
// Shared definitions for the MEM-stage SRAM data port.
// Holds the FSM state encoding, the active-low strobe levels and the datapath width.
package sram_data_port_pkg;

  localparam int   DATA_W     = 16;
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    RD_SAMPLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } memState_t;

  function automatic logic isReadState(input memState_t s);
    return s inside {RD_ADDR, RD_WAIT, RD_SAMPLE};
  endfunction

  function automatic logic isWriteState(input memState_t s);
    return s inside {WR_SETUP, WR_PULSE, WR_HOLD};
  endfunction

endpackage

// File: rtl/sram_data_port.sv
// MEM-stage data-memory port: sequences one read or write on SRAM bank ram1 and
// stalls the upstream pipeline until the access has completed.
module sram_data_port #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = sram_data_port_pkg::DATA_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [15:0]       address,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              stall,
  output logic              done,
  output logic              ram1OE,
  output logic              ram1WE,
  output logic              ram1EN,
  output logic [ADDR_W-1:0] ram1Addr,
  inout  wire  [DATA_W-1:0] ram1Data
);
  import sram_data_port_pkg::*;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  memState_t         state;
  memState_t         nextState;
  logic [3:0]        waitCnt;
  logic [3:0]        waitCntNext;
  logic [DATA_W-1:0] wdataQ;
  logic              driveEn;

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    nextState   = state;
    waitCntNext = waitCnt;
    case (state)
      IDLE: begin
        if (memWrite)     nextState = WR_SETUP;
        else if (memRead) nextState = RD_ADDR;
      end
      RD_ADDR: begin
        waitCntNext = WAIT_LOAD;
        nextState   = (WAIT_LOAD == 4'd0) ? RD_SAMPLE : RD_WAIT;
      end
      RD_WAIT: begin
        waitCntNext = waitCnt - 4'd1;
        if (waitCnt <= 4'd1) nextState = RD_SAMPLE;
      end
      RD_SAMPLE: nextState = DONE;
      WR_SETUP:  nextState = WR_PULSE;
      WR_PULSE:  nextState = WR_HOLD;
      WR_HOLD:   nextState = DONE;
      DONE:      nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Strobes are computed from the next state and registered, so each one is glitch-free
  // and already at its level for the whole cycle spent in that state.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      waitCnt  <= 4'd0;
      ram1OE   <= STROBE_OFF;
      ram1WE   <= STROBE_OFF;
      ram1EN   <= STROBE_OFF;
      ram1Addr <= '0;
      wdataQ   <= '0;
      driveEn  <= 1'b0;
      dataOut  <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= waitCntNext;
      ram1EN  <= (isReadState(nextState) || isWriteState(nextState)) ? STROBE_ON : STROBE_OFF;
      ram1OE  <= isReadState(nextState) ? STROBE_ON : STROBE_OFF;
      ram1WE  <= (nextState == WR_PULSE) ? STROBE_ON : STROBE_OFF;
      driveEn <= isWriteState(nextState);
      if (state == IDLE && nextState != IDLE) begin
        ram1Addr <= ADDR_W'(address);
        wdataQ   <= dataIn;
      end
      if (state == RD_SAMPLE) dataOut <= ram1Data;
    end
  end

  // The DONE cycle releases the pipeline even though the request inputs may still be set.
  assign stall = ((state != IDLE) && (state != DONE)) ||
                 ((state == IDLE) && (memRead || memWrite));
  assign done  = (state == DONE);

  assign ram1Data = driveEn ? wdataQ : 'z;

endmodule

// File: tb/tb_sram_data_port.sv
// Bench for sram_data_port: two instances (no read wait, three read-wait cycles), each with an
// SRAM device model, a request driver feeding an expectation queue and an independent monitor.
module tb_sram_data_port;

  typedef struct {
    bit          isWr;
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
    int          stallCyc;
    int          oeLow;
    int          weLow;
    int          drvCyc;
  } expItem_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [1:0]       memRead;
  logic [1:0]       memWrite;
  logic [1:0][15:0] address;
  logic [1:0][15:0] dataIn;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int W = (p == 0) ? 0 : 3;

    wire  [15:0] bus;
    logic [15:0] dOut;
    logic [17:0] ra;
    logic        st, dn, oe, we, en;
    logic [15:0] mem    [65536];
    logic [15:0] refMem [65536];
    expItem_t    expQ[$];

    sram_data_port #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(W)) dut (
      .CLK(CLK), .RST(RST), .memRead(memRead[p]), .memWrite(memWrite[p]),
      .address(address[p]), .dataIn(dataIn[p]), .dataOut(dOut), .stall(st), .done(dn),
      .ram1OE(oe), .ram1WE(we), .ram1EN(en), .ram1Addr(ra), .ram1Data(bus)
    );

    // Released bus floats high; write data never uses 16'hFFFF so a driven bus is distinguishable.
    for (genvar b = 0; b < 16; b++) begin : g_pu
      pullup (bus[b]);
    end

    assign bus = (!en && !oe && we) ? mem[ra[15:0]] : 16'hzzzz;
    always @(negedge CLK) if (!en && !we) mem[ra[15:0]] = bus;

    initial begin
      for (int a = 0; a < 65536; a++) begin
        mem[a]    = 16'(a * 7 + p * 3) ^ 16'h3C3C;
        refMem[a] = 16'(a * 7 + p * 3) ^ 16'h3C3C;
      end
      mem[16'h0010]    = 16'hBEEF;
      refMem[16'h0010] = 16'hBEEF;
    end

    task automatic access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
      expItem_t e;
      int n;
      e.isWr = wr;
      e.addr = a;
      if (wr) begin
        e.data = d; refMem[a] = d;
        e.cyc = 5; e.stallCyc = 4; e.oeLow = 0; e.weLow = 1; e.drvCyc = 3;
      end else begin
        e.data = refMem[a];
        e.cyc = 4 + W; e.stallCyc = 3 + W; e.oeLow = 2 + W; e.weLow = 0; e.drvCyc = 0;
      end
      expQ.push_back(e);
      memRead[p] = rd; memWrite[p] = wr; address[p] = a; dataIn[p] = d;
      @(posedge CLK); #1;
      address[p] = 16'($urandom);
      dataIn[p]  = 16'($urandom);
      n = 0;
      do begin
        @(negedge CLK);
        n++;
      end while (!dn && n < 40);
      check($sformatf("p%0d done reached", p), dn, 1'b1);
      @(posedge CLK); #1;
      memRead[p] = 1'b0; memWrite[p] = 1'b0;
    endtask

    task automatic runRandom(input int count);
      for (int i = 0; i < count; i++) begin
        int          k = $urandom_range(0, 3);
        logic [15:0] a = 16'h0060 + 16'($urandom_range(0, 15));
        logic [15:0] d = 16'($urandom);
        if (d == 16'hFFFF) d = 16'h0000;
        access(k != 1, k == 1 || k == 2, a, d);
        repeat ($urandom_range(0, 2)) begin
          @(posedge CLK); #1;
        end
      end
    endtask

    task automatic checkIdle(input string tag, input logic [15:0] expOut);
      check($sformatf("p%0d %s OE", p, tag), oe, 1'b1);
      check($sformatf("p%0d %s WE", p, tag), we, 1'b1);
      check($sformatf("p%0d %s EN", p, tag), en, 1'b1);
      check($sformatf("p%0d %s addr", p, tag), ra, 18'h0);
      check($sformatf("p%0d %s bus released", p, tag), bus, 16'hFFFF);
      check($sformatf("p%0d %s stall", p, tag), st, 1'b0);
      check($sformatf("p%0d %s done", p, tag), dn, 1'b0);
      check($sformatf("p%0d %s dataOut", p, tag), dOut, expOut);
    endtask

    expItem_t cur;
    int  cyc, stallCyc, oeLow, weLow, drvCyc;
    bit  inAcc = 1'b0, wasDone = 1'b0, overlap, addrBad, dataBad;

    always @(negedge CLK) begin
      if (RST) begin
        inAcc   = 1'b0;
        wasDone = 1'b0;
      end else begin
        if (wasDone) check($sformatf("p%0d done single pulse", p), dn, 1'b0);
        wasDone = 1'b0;
        if (st && !inAcc) begin
          inAcc = 1'b1;
          cyc = 0; stallCyc = 0; oeLow = 0; weLow = 0; drvCyc = 0;
          overlap = 1'b0; addrBad = 1'b0; dataBad = 1'b0;
        end
        if (inAcc) begin
          cyc++;
          if (st) stallCyc++;
          if (!oe) oeLow++;
          if (!we) weLow++;
          if (oe && bus !== 16'hFFFF) drvCyc++;
          if (!oe && !we) overlap = 1'b1;
          if (expQ.size() > 0) begin
            if (!en && ra !== {2'b00, expQ[0].addr}) addrBad = 1'b1;
            if (oe && bus !== 16'hFFFF && bus !== expQ[0].data) dataBad = 1'b1;
          end
          if (dn) begin
            if (expQ.size() == 0) begin
              check($sformatf("p%0d unexpected done", p), dn, 1'b0);
            end else begin
              cur = expQ.pop_front();
              if (cur.isWr) check($sformatf("p%0d sram[%h]", p, cur.addr), mem[cur.addr], cur.data);
              else          check($sformatf("p%0d read %h", p, cur.addr), dOut, cur.data);
              check($sformatf("p%0d latency", p), cyc, cur.cyc);
              check($sformatf("p%0d stall cycles", p), stallCyc, cur.stallCyc);
              check($sformatf("p%0d OE low cycles", p), oeLow, cur.oeLow);
              check($sformatf("p%0d WE low cycles", p), weLow, cur.weLow);
              check($sformatf("p%0d bus driven cycles", p), drvCyc, cur.drvCyc);
              check($sformatf("p%0d OE/WE overlap", p), overlap, 1'b0);
              check($sformatf("p%0d address on bus", p), addrBad, 1'b0);
              check($sformatf("p%0d write data on bus", p), dataBad, 1'b0);
            end
            inAcc   = 1'b0;
            wasDone = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    RST = 1'b1;
    memRead = '0; memWrite = '0; address = '0; dataIn = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    g_port[0].checkIdle("reset", 16'h0000);
    g_port[1].checkIdle("reset", 16'h0000);
    @(posedge CLK); #1;

    fork
      begin
        g_port[0].access(1'b1, 1'b0, 16'h0010, 16'h0000);
        g_port[0].access(1'b0, 1'b1, 16'h0020, 16'h1234);
        g_port[0].access(1'b0, 1'b1, 16'h0030, 16'h5555);
        g_port[0].access(1'b1, 1'b0, 16'h0030, 16'h0000);
        g_port[0].access(1'b1, 1'b1, 16'h0040, 16'hA5A5);
        g_port[0].access(1'b1, 1'b0, 16'h0040, 16'h0000);
        g_port[0].runRandom(40);
      end
      begin
        g_port[1].access(1'b1, 1'b0, 16'h0010, 16'h0000);
        g_port[1].access(1'b0, 1'b1, 16'h0030, 16'h5A5A);
        g_port[1].access(1'b1, 1'b0, 16'h0030, 16'h0000);
        g_port[1].runRandom(20);
      end
    join

    // Cut off a write in its WE pulse; dataOut currently holds 0x1234 from the read below.
    g_port[0].access(1'b1, 1'b0, 16'h0020, 16'h0000);
    memWrite[0] = 1'b1; address[0] = 16'h0050; dataIn[0] = 16'h7777;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (g_port[0].we !== 1'b0 && n < 20);
    check("p0 WE pulse before reset", g_port[0].we, 1'b0);
    #1 RST = 1'b1; memWrite[0] = 1'b0;
    @(negedge CLK);
    g_port[0].checkIdle("mid-write reset", 16'h0000);
    @(posedge CLK); #1 RST = 1'b0;
    g_port[0].access(1'b1, 1'b0, 16'h0030, 16'h0000);

    repeat (3) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
